ntt_cmd_sequencer: RTL

- Command-issuing end of the ntt_engine command interface.
- Host software pushes decoded FHE micro-ops (LOAD, STORE, LOAD_W, NTT, INTT, ADD, SUB, MULT) into an internal FIFO.
- The sequencer drains the FIFO one command at a time: it drives a single-cycle cmd_valid pulse into the engine and tracks the engine's ready drop/rise to detect completion.
- Adds source-slot packing for ALU ops, illegal-opcode filtering, a completion watchdog, and issue/done counters.

---
 rtl/ntt_isa_pkg.sv | 56 +++++
 rtl/ntt_cmd_sequencer_cmd_fifo.sv | 61 ++++++
 rtl/ntt_cmd_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ntt_isa_pkg.sv
// Shared ISA definitions for the ntt_engine command path: opcodes, the
// queued-command layout, sequencer states and opcode classification helpers.
package ntt_isa_pkg;

    localparam logic [7:0] OPC_LOAD   = 8'h02;
    localparam logic [7:0] OPC_STORE  = 8'h03;
    localparam logic [7:0] OPC_LOAD_W = 8'h04;
    localparam logic [7:0] OPC_NTT    = 8'h10;
    localparam logic [7:0] OPC_INTT   = 8'h11;
    localparam logic [7:0] OPC_ADD    = 8'h20;
    localparam logic [7:0] OPC_SUB    = 8'h21;
    localparam logic [7:0] OPC_MULT   = 8'h22;

    // The engine reads the ALU source slot from the top of the address field.
    localparam int SRC_SLOT_MSB = 47;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_HALT      = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [3:0]  slot;
        logic [3:0]  src_slot;
        logic [47:0] dma_addr;
    } cmd_entry_t;

    localparam int CMD_W = $bits(cmd_entry_t);

    function automatic logic is_legal_opcode(input logic [7:0] op);
        case (op)
            OPC_LOAD, OPC_STORE, OPC_LOAD_W, OPC_NTT, OPC_INTT,
            OPC_ADD, OPC_SUB, OPC_MULT: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_alu_opcode(input logic [7:0] op);
        case (op)
            OPC_ADD, OPC_SUB, OPC_MULT: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_xform_opcode(input logic [7:0] op);
        case (op)
            OPC_NTT, OPC_INTT: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ntt_cmd_sequencer_cmd_fifo.sv
// Synchronous FIFO with registered full/empty flags and an occupancy level.
// Pushes while full and pops while empty are ignored.
module cmd_fifo #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   level
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;
    logic [DEPTH_LOG:0]   level_next;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_next = level;
        if (do_push && !do_pop)
            level_next = level + 1'b1;
        else if (!do_push && do_pop)
            level_next = level - 1'b1;
    end

    // Pointers, level and flags; flags are registered from the next level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;
            full  <= (level_next == (DEPTH_LOG+1)'(DEPTH));
            empty <= (level_next == '0);
        end
    end

    // Storage array; contents need no reset since the flags guard every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ntt_cmd_sequencer.sv
// Issues queued FHE micro-ops to the ntt_engine one at a time, tracking
// completion through the engine's ready drop/rise, with illegal-opcode
// filtering, a completion watchdog and issue/done counters.
module ntt_cmd_sequencer
    import ntt_isa_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = 4,
    parameter int TIMEOUT   = 1000000,
    parameter int TO_W      = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_opcode,
    input  logic [3:0]           in_slot,
    input  logic [3:0]           in_src_slot,
    input  logic [47:0]          in_dma_addr,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_opcode,
    output logic [3:0]           cmd_slot,
    output logic [47:0]          cmd_dma_addr,
    input  logic                 eng_ready,
    input  logic                 err_clr,
    output logic                 busy,
    output logic [DEPTH_LOG:0]   fifo_level,
    output logic [15:0]          issued_cnt,
    output logic [15:0]          done_cnt,
    output logic                 err_illegal,
    output logic                 err_timeout,
    output logic [2:0]           dbg_state
);

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    seq_state_t      state;
    cmd_entry_t      wentry;
    cmd_entry_t      head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic [47:0]     packed_addr;
    logic [TO_W-1:0] wd;

    assign wentry    = '{opcode: in_opcode, slot: in_slot, src_slot: in_src_slot, dma_addr: in_dma_addr};
    assign in_ready  = !fifo_full;
    assign pop       = (state == S_IDLE) && !fifo_empty && eng_ready;
    assign busy      = (fifo_level != '0) || (state != S_IDLE);
    assign dbg_state = state;

    cmd_fifo #(
        .WIDTH     (CMD_W),
        .DEPTH     (DEPTH),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Address field as the engine expects it: source slot on top for ALU ops,
    // zero for transforms, the pushed DMA address otherwise.
    always_comb begin
        packed_addr = head.dma_addr;
        if (is_alu_opcode(head.opcode)) begin
            packed_addr = '0;
            packed_addr[SRC_SLOT_MSB -: 4] = head.src_slot;
        end else if (is_xform_opcode(head.opcode)) begin
            packed_addr = '0;
        end
    end

    // Issue FSM with registered command outputs, counters, watchdog and errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cmd_valid    <= 1'b0;
            cmd_opcode   <= '0;
            cmd_slot     <= '0;
            cmd_dma_addr <= '0;
            issued_cnt   <= '0;
            done_cnt     <= '0;
            err_illegal  <= 1'b0;
            err_timeout  <= 1'b0;
            wd           <= '0;
        end else begin
            cmd_valid <= 1'b0;
            // A fresh illegal drop in the same cycle overrides the clear below.
            if (err_clr) err_illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        if (is_legal_opcode(head.opcode)) begin
                            cmd_opcode   <= head.opcode;
                            cmd_slot     <= head.slot;
                            cmd_dma_addr <= packed_addr;
                            cmd_valid    <= 1'b1;
                            state        <= S_ISSUE;
                        end else begin
                            err_illegal <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    issued_cnt <= issued_cnt + 16'd1;
                    wd         <= '0;
                    state      <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!eng_ready) begin
                        wd    <= '0;
                        state <= S_WAIT_DONE;
                    end else if (wd == WD_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_HALT;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (eng_ready) begin
                        done_cnt <= done_cnt + 16'd1;
                        state    <= S_IDLE;
                    end else if (wd == WD_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_HALT;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_HALT: begin
                    if (err_clr) begin
                        err_timeout <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
